// File: rtl/time_edit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : time_edit_ctrl
// Purpose  : Watch time-setting controller. Walks hours -> minutes -> seconds
//            edit fields from the config button, steps the selected field
//            with inc/dec (with auto-repeat), freezes the time counter while
//            editing and commits the edited time with a one-cycle strobe.
// Revision : 1.0 - initial release
// ============================================================================
module time_edit_ctrl #(
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int TIMEOUT_S     = 30,
  parameter int BLINK_HALF    = 25_000_000
) (
  input  logic       clock,
  input  logic       reset_i,
  input  logic       btn_config_i,
  input  logic       btn_inc_i,
  input  logic       btn_dec_i,
  input  logic       tick_1hz_i,
  input  logic [5:0] seconds_i,
  input  logic [5:0] minutes_i,
  input  logic [4:0] hours_i,
  output logic       count_enable_o,
  output logic       load_time_o,
  output logic [5:0] load_seconds_o,
  output logic [5:0] load_minutes_o,
  output logic [4:0] load_hours_o,
  output logic [1:0] edit_field_o,
  output logic       blink_o
);

  localparam logic [2:0] c_st_run    = 3'd0;
  localparam logic [2:0] c_st_ed_h   = 3'd1;
  localparam logic [2:0] c_st_ed_m   = 3'd2;
  localparam logic [2:0] c_st_ed_s   = 3'd3;
  localparam logic [2:0] c_st_commit = 3'd4;

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic        r_cfg_prev, r_inc_prev, r_dec_prev;
  logic [4:0]  r_hours;
  logic [5:0]  r_minutes, r_seconds;
  logic [31:0] r_hold, r_idle, r_blink_cnt;
  logic        r_rep;
  logic        r_count_enable, r_load_time, r_blink;
  logic [1:0]  r_edit_field;

  logic w_cfg_edge, w_inc_edge, w_dec_edge;
  logic w_editing, w_nxt_editing, w_one_held, w_rep_fire;
  logic w_step_inc, w_step_dec, w_step, w_activity, w_timeout, w_enter_edit;
  logic [1:0] w_field_nxt;

  assign w_cfg_edge = btn_config_i & ~r_cfg_prev;
  assign w_inc_edge = btn_inc_i & ~r_inc_prev;
  assign w_dec_edge = btn_dec_i & ~r_dec_prev;

  assign w_editing     = (r_state == c_st_ed_h) || (r_state == c_st_ed_m) || (r_state == c_st_ed_s);
  assign w_nxt_editing = (w_state_nxt == c_st_ed_h) || (w_state_nxt == c_st_ed_m) ||
                         (w_state_nxt == c_st_ed_s);
  assign w_one_held    = btn_inc_i ^ btn_dec_i;

  // First repeat fires after REPEAT_DELAY held cycles, later ones every REPEAT_PERIOD
  assign w_rep_fire = w_editing && w_one_held &&
                      (r_rep ? (r_hold == 32'(REPEAT_PERIOD)) : (r_hold == 32'(REPEAT_DELAY)));

  // A coincident config edge always takes priority over a step
  assign w_step_inc = w_editing && !w_cfg_edge && btn_inc_i && !btn_dec_i && (w_inc_edge || w_rep_fire);
  assign w_step_dec = w_editing && !w_cfg_edge && btn_dec_i && !btn_inc_i && (w_dec_edge || w_rep_fire);
  assign w_step     = w_step_inc || w_step_dec;

  assign w_activity = w_cfg_edge || w_inc_edge || w_dec_edge || w_step;
  assign w_timeout  = w_editing && !w_activity && tick_1hz_i && (r_idle == 32'(TIMEOUT_S - 1));

  assign w_enter_edit = w_nxt_editing && (w_state_nxt != r_state);

  assign load_hours_o   = r_hours;
  assign load_minutes_o = r_minutes;
  assign load_seconds_o = r_seconds;
  assign count_enable_o = r_count_enable;
  assign load_time_o    = r_load_time;
  assign edit_field_o   = r_edit_field;
  assign blink_o        = r_blink;

  // Next-state selection for the edit sequence
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_run:    if (w_cfg_edge) w_state_nxt = c_st_ed_h;
      c_st_ed_h:   if (w_cfg_edge) w_state_nxt = c_st_ed_m;
                   else if (w_timeout) w_state_nxt = c_st_run;
      c_st_ed_m:   if (w_cfg_edge) w_state_nxt = c_st_ed_s;
                   else if (w_timeout) w_state_nxt = c_st_run;
      c_st_ed_s:   if (w_cfg_edge) w_state_nxt = c_st_commit;
                   else if (w_timeout) w_state_nxt = c_st_run;
      default:     w_state_nxt = c_st_run;
    endcase
  end

  // Field indicator that follows the next state
  always_comb begin
    w_field_nxt = 2'd0;
    case (w_state_nxt)
      c_st_ed_h: w_field_nxt = 2'd1;
      c_st_ed_m: w_field_nxt = 2'd2;
      c_st_ed_s: w_field_nxt = 2'd3;
      default:   w_field_nxt = 2'd0;
    endcase
  end

  // State, button history and registered status outputs
  always_ff @(posedge clock or negedge reset_i) begin
    if (!reset_i) begin
      r_state        <= c_st_run;
      r_cfg_prev     <= 1'b1;
      r_inc_prev     <= 1'b1;
      r_dec_prev     <= 1'b1;
      r_count_enable <= 1'b1;
      r_load_time    <= 1'b0;
      r_edit_field   <= 2'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_cfg_prev     <= btn_config_i;
      r_inc_prev     <= btn_inc_i;
      r_dec_prev     <= btn_dec_i;
      r_count_enable <= (w_state_nxt == c_st_run);
      r_load_time    <= (w_state_nxt == c_st_commit);
      r_edit_field   <= w_field_nxt;
    end
  end

  // Edit registers: sanitised capture on entry, wrapping steps while editing
  always_ff @(posedge clock or negedge reset_i) begin
    if (!reset_i) begin
      r_hours   <= 5'd0;
      r_minutes <= 6'd0;
      r_seconds <= 6'd0;
    end else if (r_state == c_st_run && w_cfg_edge) begin
      r_hours   <= (hours_i   > 5'd23) ? 5'd0 : hours_i;
      r_minutes <= (minutes_i > 6'd59) ? 6'd0 : minutes_i;
      r_seconds <= (seconds_i > 6'd59) ? 6'd0 : seconds_i;
    end else if (w_step) begin
      case (r_state)
        c_st_ed_h:
          if (w_step_inc) r_hours <= (r_hours == 5'd23) ? 5'd0 : r_hours + 5'd1;
          else            r_hours <= (r_hours == 5'd0) ? 5'd23 : r_hours - 5'd1;
        c_st_ed_m:
          if (w_step_inc) r_minutes <= (r_minutes == 6'd59) ? 6'd0 : r_minutes + 6'd1;
          else            r_minutes <= (r_minutes == 6'd0) ? 6'd59 : r_minutes - 6'd1;
        default:
          if (w_step_inc) r_seconds <= (r_seconds == 6'd59) ? 6'd0 : r_seconds + 6'd1;
          else            r_seconds <= (r_seconds == 6'd0) ? 6'd59 : r_seconds - 6'd1;
      endcase
    end
  end

  // Hold counter for auto-repeat; restarts on release, both held or field change
  always_ff @(posedge clock or negedge reset_i) begin
    if (!reset_i) begin
      r_hold <= 32'd0;
      r_rep  <= 1'b0;
    end else if (!w_editing || !w_one_held || w_cfg_edge) begin
      r_hold <= 32'd0;
      r_rep  <= 1'b0;
    end else if (w_rep_fire) begin
      r_hold <= 32'd1;
      r_rep  <= 1'b1;
    end else begin
      r_hold <= r_hold + 32'd1;
    end
  end

  // Inactivity counter in seconds ticks while editing
  always_ff @(posedge clock or negedge reset_i) begin
    if (!reset_i) begin
      r_idle <= 32'd0;
    end else if (!w_editing || w_activity) begin
      r_idle <= 32'd0;
    end else if (tick_1hz_i) begin
      r_idle <= r_idle + 32'd1;
    end
  end

  // Blink phase; forced visible on field entry and on each step
  always_ff @(posedge clock or negedge reset_i) begin
    if (!reset_i) begin
      r_blink     <= 1'b0;
      r_blink_cnt <= 32'd0;
    end else if (!w_nxt_editing) begin
      r_blink     <= 1'b0;
      r_blink_cnt <= 32'd0;
    end else if (w_enter_edit || w_step) begin
      r_blink     <= 1'b1;
      r_blink_cnt <= 32'd0;
    end else if (r_blink_cnt == 32'(BLINK_HALF - 1)) begin
      r_blink     <= ~r_blink;
      r_blink_cnt <= 32'd0;
    end else begin
      r_blink_cnt <= r_blink_cnt + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_time_edit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_edit_ctrl
// Purpose  : Directed self-checking bench for time_edit_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_time_edit_ctrl;

  logic       clock = 1'b0;
  logic       reset_i = 1'b0;
  logic       btn_config_i = 1'b0, btn_inc_i = 1'b0, btn_dec_i = 1'b0, tick_1hz_i = 1'b0;
  logic [5:0] seconds_i = 6'd0, minutes_i = 6'd0;
  logic [4:0] hours_i = 5'd0;
  logic       count_enable_o, load_time_o, blink_o;
  logic [5:0] load_seconds_o, load_minutes_o;
  logic [4:0] load_hours_o;
  logic [1:0] edit_field_o;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int exp_pulses = 0;

  time_edit_ctrl #(
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(4),
    .TIMEOUT_S    (3),
    .BLINK_HALF   (6)
  ) dut (
    .clock         (clock),
    .reset_i       (reset_i),
    .btn_config_i  (btn_config_i),
    .btn_inc_i     (btn_inc_i),
    .btn_dec_i     (btn_dec_i),
    .tick_1hz_i    (tick_1hz_i),
    .seconds_i     (seconds_i),
    .minutes_i     (minutes_i),
    .hours_i       (hours_i),
    .count_enable_o(count_enable_o),
    .load_time_o   (load_time_o),
    .load_seconds_o(load_seconds_o),
    .load_minutes_o(load_minutes_o),
    .load_hours_o  (load_hours_o),
    .edit_field_o  (edit_field_o),
    .blink_o       (blink_o)
  );

  always #5 clock = ~clock;

  // Count commit strobes seen on the falling edge
  always @(negedge clock) if (load_time_o) pulses++;

  task automatic check(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic cfg_pulse();
    btn_config_i = 1'b1; cyc();
    btn_config_i = 1'b0; cyc();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ce"},    int'(count_enable_o), 1);
    check({tag, "_ld"},    int'(load_time_o), 0);
    check({tag, "_sec"},   int'(load_seconds_o), 0);
    check({tag, "_min"},   int'(load_minutes_o), 0);
    check({tag, "_hr"},    int'(load_hours_o), 0);
    check({tag, "_field"}, int'(edit_field_o), 0);
    check({tag, "_blink"}, int'(blink_o), 0);
  endtask

  initial begin
    // Reset with config held: no edge on release
    btn_config_i = 1'b1;
    cyc(3);
    check_reset_vals("rst");
    reset_i = 1'b1;
    cyc(3);
    check("held_cfg_field", int'(edit_field_o), 0);
    check("held_cfg_ce", int'(count_enable_o), 1);
    btn_config_i = 1'b0;
    cyc();
    check("held_cfg_pulses", pulses, 0);

    // Main edit flow from 12:34:56
    hours_i = 5'd12; minutes_i = 6'd34; seconds_i = 6'd56;
    btn_config_i = 1'b1; cyc();
    check("enter_field", int'(edit_field_o), 1);
    check("enter_ce", int'(count_enable_o), 0);
    check("enter_hr", int'(load_hours_o), 12);
    check("enter_min", int'(load_minutes_o), 34);
    check("enter_sec", int'(load_seconds_o), 56);
    check("enter_blink", int'(blink_o), 1);
    btn_config_i = 1'b0; cyc();
    btn_inc_i = 1'b1; cyc();
    check("inc1_hr", int'(load_hours_o), 13);
    btn_inc_i = 1'b0; cyc();
    btn_inc_i = 1'b1; cyc();
    btn_inc_i = 1'b0; cyc();
    check("inc2_hr", int'(load_hours_o), 14);
    btn_config_i = 1'b1; cyc();
    check("min_field", int'(edit_field_o), 2);
    btn_config_i = 1'b0; cyc();
    btn_dec_i = 1'b1; cyc();
    btn_dec_i = 1'b0; cyc();
    check("dec_min", int'(load_minutes_o), 33);
    btn_config_i = 1'b1; cyc();
    check("sec_field", int'(edit_field_o), 3);
    check("sec_blink_on", int'(blink_o), 1);
    btn_config_i = 1'b0; cyc(5);
    check("blink_still_on", int'(blink_o), 1);
    cyc();
    check("blink_off", int'(blink_o), 0);
    btn_config_i = 1'b1; cyc();
    exp_pulses++;
    check("commit_ld", int'(load_time_o), 1);
    check("commit_ce", int'(count_enable_o), 0);
    check("commit_hr", int'(load_hours_o), 14);
    check("commit_min", int'(load_minutes_o), 33);
    check("commit_sec", int'(load_seconds_o), 56);
    btn_config_i = 1'b0; cyc();
    check("after_commit_ld", int'(load_time_o), 0);
    check("after_commit_ce", int'(count_enable_o), 1);
    check("commit_pulses", pulses, exp_pulses);

    // Out-of-range capture is sanitised
    hours_i = 5'd25; minutes_i = 6'd60; seconds_i = 6'd63;
    cfg_pulse();
    check("clamp_hr", int'(load_hours_o), 0);
    check("clamp_min", int'(load_minutes_o), 0);
    check("clamp_sec", int'(load_seconds_o), 0);
    cfg_pulse(); cfg_pulse(); cfg_pulse();
    exp_pulses++;

    // Wrap rules
    hours_i = 5'd23; minutes_i = 6'd0; seconds_i = 6'd59;
    cfg_pulse();
    btn_inc_i = 1'b1; cyc(); btn_inc_i = 1'b0; cyc();
    check("wrap_hr", int'(load_hours_o), 0);
    cfg_pulse();
    btn_dec_i = 1'b1; cyc(); btn_dec_i = 1'b0; cyc();
    check("wrap_min", int'(load_minutes_o), 59);
    cfg_pulse();
    btn_inc_i = 1'b1; cyc(); btn_inc_i = 1'b0; cyc();
    check("wrap_sec", int'(load_seconds_o), 0);
    cfg_pulse();
    exp_pulses++;
    check("wrap_pulses", pulses, exp_pulses);

    // Auto-repeat on minutes from 0
    hours_i = 5'd0; minutes_i = 6'd0; seconds_i = 6'd0;
    cfg_pulse(); cfg_pulse();
    btn_inc_i = 1'b1;
    cyc(10);
    check("rep_10", int'(load_minutes_o), 1);
    cyc();
    check("rep_11", int'(load_minutes_o), 2);
    cyc(14);
    check("rep_25", int'(load_minutes_o), 5);
    btn_inc_i = 1'b0; cyc();
    check("rep_release", int'(load_minutes_o), 5);
    btn_inc_i = 1'b1; btn_dec_i = 1'b1;
    cyc(20);
    check("both_held", int'(load_minutes_o), 5);
    btn_inc_i = 1'b0; btn_dec_i = 1'b0; cyc();

    // Timeout after three idle ticks
    btn_inc_i = 1'b1; cyc(); btn_inc_i = 1'b0; cyc();
    check("to_min", int'(load_minutes_o), 6);
    tick_1hz_i = 1'b1; cyc(); tick_1hz_i = 1'b0; cyc();
    tick_1hz_i = 1'b1; cyc(); tick_1hz_i = 1'b0; cyc();
    check("to_still_edit", int'(edit_field_o), 2);
    tick_1hz_i = 1'b1; cyc();
    check("to_ce", int'(count_enable_o), 1);
    check("to_field", int'(edit_field_o), 0);
    tick_1hz_i = 1'b0; cyc();
    check("to_pulses", pulses, exp_pulses);

    // Config wins over coincident inc
    hours_i = 5'd7; minutes_i = 6'd8; seconds_i = 6'd9;
    cfg_pulse();
    btn_config_i = 1'b1; btn_inc_i = 1'b1; cyc();
    check("cfg_win_field", int'(edit_field_o), 2);
    check("cfg_win_hr", int'(load_hours_o), 7);
    btn_config_i = 1'b0; btn_inc_i = 1'b0; cyc();
    cfg_pulse();
    check("pre_rst_field", int'(edit_field_o), 3);

    // Asynchronous reset mid-edit
    reset_i = 1'b0;
    #1;
    check_reset_vals("midrst");
    cyc(2);
    reset_i = 1'b1;
    cyc(2);
    check("final_ce", int'(count_enable_o), 1);
    check("final_pulses", pulses, exp_pulses);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
